// File: rtl/regfile_dump_reader_pkg.sv
// Shared definitions for the register-file dump reader: default widths and
// FSM state encodings, also used by the CPU debug controller.
package regfile_dump_reader_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_HALT_WAIT = 3'd1;
  localparam logic [2:0] S_FETCH     = 3'd2;
  localparam logic [2:0] S_SEND      = 3'd3;
  localparam logic [2:0] S_FINISH    = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE      = S_IDLE,
    ST_HALT_WAIT = S_HALT_WAIT,
    ST_FETCH     = S_FETCH,
    ST_SEND      = S_SEND,
    ST_FINISH    = S_FINISH
  } state_e;

endpackage

// File: rtl/regfile_dump_reader.sv
// Debug-side register file reader: halts the pipeline, walks a (possibly
// wrapping) index range through the debug read port and streams each value
// with its index over a valid/ready handshake.
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic              halt_req,
  input  logic              halt_ack,
  output logic [ADDR_W-1:0] DbgReadReg,
  input  logic [DATA_W-1:0] DbgReadData,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ADDR_W-1:0] out_index_q, out_index_d;
  logic              out_last_q, out_last_d;
  logic              out_valid_q, out_valid_d;

  // State, range counter and output word registers; reset clears everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      last_q      <= '0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state logic: latch range, wait for halt, fetch/send each index.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    last_d      = last_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d   = first_reg;
          last_d  = last_reg;
          state_d = ST_HALT_WAIT;
        end
      end
      ST_HALT_WAIT: begin
        if (halt_ack) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        // Read port is combinational, so data for idx is valid this cycle.
        out_data_d  = DbgReadData;
        out_index_d = idx_q;
        out_last_d  = (idx_q == last_q);
        out_valid_d = 1'b1;
        state_d     = ST_SEND;
      end
      ST_SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            state_d = ST_FINISH;
          end else begin
            // Natural ADDR_W-bit wrap gives the modulo-32 walk.
            idx_d   = idx_q + ADDR_W'(1);
            state_d = ST_FETCH;
          end
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Halt is held from the cycle after start until the dump has drained.
  assign halt_req   = (state_q == ST_HALT_WAIT) || (state_q == ST_FETCH) ||
                      (state_q == ST_SEND);
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_FINISH);
  assign DbgReadReg = idx_q;
  assign out_data   = out_data_q;
  assign out_index  = out_index_q;
  assign out_last   = out_last_q;
  assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader with a behavioural register file.
module tb_regfile_dump_reader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  first_reg = '0;
  logic [4:0]  last_reg = '0;
  logic        halt_req;
  logic        halt_ack = 1'b0;
  logic [4:0]  DbgReadReg;
  logic [31:0] DbgReadData;
  logic [31:0] out_data;
  logic [4:0]  out_index;
  logic        out_last;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  regfile_dump_reader #(.DATA_W(32), .ADDR_W(5)) dut (
    .clock(clock), .reset(reset), .start(start),
    .first_reg(first_reg), .last_reg(last_reg),
    .halt_req(halt_req), .halt_ack(halt_ack),
    .DbgReadReg(DbgReadReg), .DbgReadData(DbgReadData),
    .out_data(out_data), .out_index(out_index), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Register file contents: r8..r11 fixed patterns, r0 reads zero.
  function automatic logic [31:0] rf_val(input logic [4:0] i);
    case (i)
      5'd0:    return 32'h0000_0000;
      5'd8:    return 32'h1111_1111;
      5'd9:    return 32'h2222_2222;
      5'd10:   return 32'h3333_3333;
      5'd11:   return 32'h4444_4444;
      default: return 32'hA500_0000 | {27'd0, i};
    endcase
  endfunction

  always_comb DbgReadData = rf_val(DbgReadReg);

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse start with a range; leaves the DUT one cycle into HALT_WAIT.
  task automatic kick(input logic [4:0] f, input logic [4:0] l);
    first_reg = f;
    last_reg  = l;
    start     = 1'b1;
    step();
    start     = 1'b0;
    chk("halt_req_after_start", {31'd0, halt_req}, 32'd1);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  // Collects every word of f..l with out_ready high; ends in the done cycle.
  task automatic collect(input logic [4:0] f, input logic [4:0] l);
    logic [4:0] diff;
    logic [4:0] idx_e;
    int n;
    int w;
    diff = l - f;
    n = int'(diff) + 1;
    out_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      idx_e = f + 5'(k);
      w = 0;
      while (!out_valid && w < 12) begin
        step();
        w++;
      end
      chk("valid_within_bound", {31'd0, out_valid}, 32'd1);
      if (k > 0) chk("gap_cycles", 32'(w), 32'd1);
      chk("index", {27'd0, out_index}, {27'd0, idx_e});
      chk("data", out_data, rf_val(idx_e));
      chk("last", {31'd0, out_last}, {31'd0, (k == n - 1)});
      $display("word k=%0d index=%0d data=%08h last=%0b", k, out_index, out_data, out_last);
      step();
      if (k < n - 1) chk("no_done_mid", {31'd0, done}, 32'd0);
    end
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("halt_drop_with_done", {31'd0, halt_req}, 32'd0);
    chk("valid_clear_after_last", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic idle_step();
    step();
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    chk("halt_idle", {31'd0, halt_req}, 32'd0);
  endtask

  initial begin
    // Reset values
    step();
    step();
    chk("rst_halt_req", {31'd0, halt_req}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_index", {27'd0, out_index}, 32'd0);
    chk("rst_dbg_reg", {27'd0, DbgReadReg}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    step();

    // Basic range 8..11, ack two cycles after halt_req, exact first-word latency
    out_ready = 1'b1;
    kick(5'd8, 5'd11);
    step();
    chk("no_valid_before_ack", {31'd0, out_valid}, 32'd0);
    halt_ack = 1'b1;
    step();
    chk("valid_lat_1", {31'd0, out_valid}, 32'd0);
    step();
    chk("valid_lat_2", {31'd0, out_valid}, 32'd1);
    collect(5'd8, 5'd11);
    idle_step();
    halt_ack = 1'b0;

    // Wrap through r31 and r0
    kick(5'd30, 5'd1);
    halt_ack = 1'b1;
    collect(5'd30, 5'd1);
    idle_step();
    halt_ack = 1'b0;

    // Single word with 7 cycles of backpressure
    out_ready = 1'b0;
    kick(5'd5, 5'd5);
    halt_ack = 1'b1;
    step();
    step();
    chk("bp_valid_up", {31'd0, out_valid}, 32'd1);
    for (int c = 0; c < 7; c++) begin
      step();
      chk("bp_valid_hold", {31'd0, out_valid}, 32'd1);
      chk("bp_data_hold", out_data, rf_val(5'd5));
      chk("bp_index_hold", {27'd0, out_index}, 32'd5);
    end
    chk("bp_last", {31'd0, out_last}, 32'd1);
    collect(5'd5, 5'd5);
    idle_step();
    halt_ack = 1'b0;

    // Halt gating: 20 cycles without ack
    out_ready = 1'b1;
    kick(5'd2, 5'd3);
    for (int c = 0; c < 20; c++) begin
      step();
      chk("gate_no_valid", {31'd0, out_valid}, 32'd0);
      chk("gate_halt_held", {31'd0, halt_req}, 32'd1);
    end
    halt_ack = 1'b1;
    step();
    chk("gate_lat_1", {31'd0, out_valid}, 32'd0);
    step();
    chk("gate_lat_2", {31'd0, out_valid}, 32'd1);
    collect(5'd2, 5'd3);
    idle_step();
    halt_ack = 1'b0;

    // Reset while word 2 of 4 is in SEND
    out_ready = 1'b0;
    kick(5'd12, 5'd15);
    halt_ack = 1'b1;
    step();
    step();
    chk("mid_w1_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();
    chk("mid_w2_valid", {31'd0, out_valid}, 32'd1);
    chk("mid_w2_index", {27'd0, out_index}, 32'd13);
    reset = 1'b1;
    step();
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_halt", {31'd0, halt_req}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    halt_ack = 1'b0;
    step();
    chk("mid_post_done", {31'd0, done}, 32'd0);
    kick(5'd12, 5'd15);
    halt_ack = 1'b1;
    collect(5'd12, 5'd15);
    idle_step();
    halt_ack = 1'b0;

    // Start while busy is ignored; start during done is not accepted
    out_ready = 1'b0;
    kick(5'd20, 5'd22);
    halt_ack = 1'b1;
    step();
    step();
    first_reg = 5'd3;
    last_reg  = 5'd4;
    start     = 1'b1;
    step();
    start     = 1'b0;
    collect(5'd20, 5'd22);
    start = 1'b1;
    idle_step();
    start = 1'b0;
    step();
    chk("start_in_done_ignored", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
